iagu_feeder: RTL

//  Input address generator and feeder: walks the input tile in the IO buffer (col inner, piece, row outer).

---
 rtl/npu_agu_pkg.sv | 20 ++
 rtl/iagu_skid_fifo.sv | 62 ++++++
 rtl/iagu_feeder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/npu_agu_pkg.sv
// Types and widths shared by the input and output address generators of the NPU.
package npu_agu_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } agu_state_e;

  typedef struct packed {
    logic [7:0] col;
    logic [7:0] piece;
    logic [7:0] row;
  } loop_cnt_t;

endpackage

// File: rtl/iagu_skid_fifo.sv
// Synchronous skid FIFO holding buffer read returns until the XPE array accepts them.
module iagu_skid_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !do_pop && !flush));

endmodule

// File: rtl/iagu_feeder.sv
// Input AGU + feeder: walks the input tile (col inner, piece, row outer) and streams words to the XPE array.
// Optional build macro IAGU_PERF_CNT_EN adds the stall_cnt performance counter port.
module iagu_feeder #(
  parameter int ADDR_W = npu_agu_pkg::ADDR_W,
  parameter int DATA_W = npu_agu_pkg::DATA_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [1:0]        buffer_flag,
  input  logic [7:0]        in_x_length,
  input  logic [7:0]        in_y_length,
  input  logic [7:0]        in_piece,
  input  logic [ADDR_W-1:0] addr_start_l,
  input  logic [7:0]        jump_length,
  output logic [ADDR_W-1:0] i_r_addr,
  output logic              i_r_en,
  output logic              i_buffer_select,
  input  logic [DATA_W-1:0] i_r_data,
  output logic [DATA_W-1:0] feed_data,
  output logic              feed_valid,
  input  logic              feed_ready,
  output logic              load_end
`ifdef IAGU_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  import npu_agu_pkg::*;

  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int INF_W = $clog2(RD_LAT + 1);

  agu_state_e        state, state_nxt;
  loop_cnt_t         cnt;
  logic [7:0]        x_len, piece_len, y_len, jump;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              col_end, piece_end, row_end, last_rd;
  logic              push, pop;
  logic [ADDR_W-1:0] addr_step;

  assign i_buffer_select = |buffer_flag;

  assign col_end   = (cnt.col   == x_len     - 8'd1);
  assign piece_end = (cnt.piece == piece_len - 8'd1);
  assign row_end   = (cnt.row   == y_len     - 8'd1);
  assign last_rd   = col_end && piece_end && row_end;
  assign addr_step = (col_end && piece_end) ? ADDR_W'({1'b0, jump} + 9'd1) : ADDR_W'(1);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + INF_W'(rd_vld_p[i]);
  end

  // Credit: never have more words owed than the FIFO can hold.
  assign i_r_en = (state == RUN) && !fifo_full &&
                  ((int'(fifo_count) + int'(inflight)) < FIFO_D);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (i_r_en && last_rd) state_nxt = DRAIN;
      // Finish in the cycle the final word is taken, so load_end lands one cycle later.
      DRAIN:   if (inflight == '0 && fifo_count == CNT_W'(pop)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start_calculate) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign load_end = (state == DONE);

  // Issue stage: loop counters and read address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_len     <= '0;
      piece_len <= '0;
      y_len     <= '0;
      jump      <= '0;
      cnt       <= '0;
      i_r_addr  <= '0;
    end else if (start_calculate) begin
      x_len     <= in_x_length;
      piece_len <= in_piece;
      y_len     <= in_y_length;
      jump      <= jump_length;
      cnt       <= '0;
      i_r_addr  <= addr_start_l;
    end else if (i_r_en) begin
      i_r_addr <= i_r_addr + addr_step;
      if (col_end) begin
        cnt.col <= '0;
        if (piece_end) begin
          cnt.piece <= '0;
          cnt.row   <= row_end ? 8'd0 : cnt.row + 8'd1;
        end else begin
          cnt.piece <= cnt.piece + 8'd1;
        end
      end else begin
        cnt.col <= cnt.col + 8'd1;
      end
    end
  end

  // Return stage: tag each read so its data is captured RD_LAT cycles later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 rd_vld_p <= '0;
    else if (start_calculate) rd_vld_p <= '0;
    else                      rd_vld_p <= RD_LAT'({rd_vld_p, i_r_en});
  end

  assign push       = rd_vld_p[RD_LAT-1];
  assign feed_valid = !fifo_empty;
  assign pop        = feed_valid && feed_ready;

  // Feed stage: skid FIFO towards the XPE array
  iagu_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_calculate),
    .push      (push),
    .push_data (i_r_data),
    .pop       (pop),
    .head      (feed_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IAGU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                    stall_cnt <= '0;
    else if (start_calculate)                                    stall_cnt <= '0;
    else if (feed_valid && !feed_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
